// File: rtl/multi_chess_clock.sv
// N-player chess clock: per-player second counters, round-robin hand-off, Fischer increment,
// pause/resume and flag detection. All outputs registered; one-cycle input-to-output latency.
module multi_chess_clock #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 10,
  parameter int INIT_TIME = 600,
  parameter int INCREMENT = 0,
  localparam int IDX_W    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [N_PLAYERS-1:0]          buttons,
  input  logic                          pause,
  output logic [N_PLAYERS*TIME_W-1:0]   times,
  output logic [N_PLAYERS-1:0]          active,
  output logic [1:0]                    state_code,
  output logic [IDX_W-1:0]              flag_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    FLAG   = 2'b11
  } state_t;

  localparam logic [31:0] TIME_MAX = 32'((64'd1 << TIME_W) - 64'd1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  flag_q, flag_d;
  logic [TIME_W-1:0] times_q [N_PLAYERS];
  logic [TIME_W-1:0] times_d [N_PLAYERS];
  logic [TIME_W-1:0] cur;
  logic [31:0]       handoff_sum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      flag_q  <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        times_q[i] <= TIME_W'(INIT_TIME);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      flag_q  <= flag_d;
      for (int i = 0; i < N_PLAYERS; i++) begin
        times_q[i] <= times_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flag_d      = flag_q;
    times_d     = times_q;
    cur         = times_q[idx_q];
    handoff_sum = 32'(cur) - 32'(tick) + 32'(INCREMENT);

    unique case (state_q)
      IDLE: begin
        // Descending scan so the lowest-index pressed button wins.
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
          if (buttons[i]) begin
            idx_d   = IDX_W'(i);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (tick && cur == TIME_W'(1)) begin
          times_d[idx_q] = '0;
          flag_d         = idx_q;
          state_d        = FLAG;
        end else if (pause) begin
          if (tick && cur != '0) begin
            times_d[idx_q] = cur - TIME_W'(1);
          end
          state_d = PAUSED;
        end else if (buttons[idx_q]) begin
          times_d[idx_q] = (handoff_sum > TIME_MAX) ? TIME_W'(TIME_MAX) : TIME_W'(handoff_sum);
          idx_d          = (idx_q == IDX_W'(N_PLAYERS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else if (tick && cur != '0) begin
          times_d[idx_q] = cur - TIME_W'(1);
        end
      end
      PAUSED: begin
        if (pause) begin
          state_d = RUN;
        end
      end
      FLAG: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_times
    assign times[g*TIME_W +: TIME_W] = times_q[g];
  end

  assign active     = (state_q == IDLE) ? '0 : (N_PLAYERS'(1) << idx_q);
  assign state_code = state_q;
  assign flag_idx   = flag_q;

endmodule

// File: tb/tb_multi_chess_clock.sv
// Randomized + directed bench: two clock instances (different widths) checked against a
// behavioural game model through per-instance expectation queues and a free-running monitor.
module tb_multi_chess_clock;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] buttons = 3'b000;

  logic [29:0] times_a;
  logic [2:0]  active_a;
  logic [1:0]  state_a;
  logic [1:0]  flag_a;
  logic [8:0]  times_b;
  logic [2:0]  active_b;
  logic [1:0]  state_b;
  logic [1:0]  flag_b;

  always #5 clk = ~clk;

  multi_chess_clock #(.N_PLAYERS(3), .TIME_W(10), .INIT_TIME(5), .INCREMENT(2)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .buttons(buttons), .pause(pause),
    .times(times_a), .active(active_a), .state_code(state_a), .flag_idx(flag_a)
  );

  multi_chess_clock #(.N_PLAYERS(3), .TIME_W(3), .INIT_TIME(7), .INCREMENT(2)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .buttons(buttons), .pause(pause),
    .times(times_b), .active(active_b), .state_code(state_b), .flag_idx(flag_b)
  );

  typedef struct packed {
    logic [29:0] t;
    logic [2:0]  a;
    logic [1:0]  s;
    logic [1:0]  f;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int passed = 0;

  // Game model: state 0=idle 1=running 2=paused 3=flagged; one slot per instance.
  int m_t   [2][3];
  int m_act [2];
  int m_st  [2];
  int m_fl  [2];
  int p_w   [2] = '{10, 3};
  int p_ini [2] = '{5, 7};
  int p_inc [2] = '{2, 2};

  task automatic model_step(input int d, input bit rst, input bit tk, input bit ps,
                            input logic [2:0] btn);
    int maxv, v;
    maxv = (1 << p_w[d]) - 1;
    if (!rst) begin
      for (int i = 0; i < 3; i++) m_t[d][i] = p_ini[d];
      m_act[d] = 0;
      m_st[d]  = 0;
      m_fl[d]  = 0;
      return;
    end
    case (m_st[d])
      0: if (btn != 3'b000) begin
        m_act[d] = btn[0] ? 0 : (btn[1] ? 1 : 2);
        m_st[d]  = 1;
      end
      1: begin
        if (tk && m_t[d][m_act[d]] == 1) begin
          m_t[d][m_act[d]] = 0;
          m_fl[d] = m_act[d];
          m_st[d] = 3;
        end else if (ps) begin
          if (tk && m_t[d][m_act[d]] > 0) m_t[d][m_act[d]]--;
          m_st[d] = 2;
        end else if (btn[m_act[d]]) begin
          v = m_t[d][m_act[d]] - int'(tk) + p_inc[d];
          m_t[d][m_act[d]] = (v > maxv) ? maxv : v;
          m_act[d] = (m_act[d] + 1) % 3;
        end else if (tk && m_t[d][m_act[d]] > 0) begin
          m_t[d][m_act[d]]--;
        end
      end
      2: if (ps) m_st[d] = 1;
      default: ;
    endcase
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.t = '0;
    for (int i = 0; i < 3; i++) e.t = e.t | (30'(m_t[d][i]) << (i * p_w[d]));
    e.a = (m_st[d] == 0) ? 3'b000 : 3'(1 << m_act[d]);
    e.s = 2'(m_st[d]);
    e.f = 2'(m_fl[d]);
    return e;
  endfunction

  task automatic drive(input bit rst, input bit tk, input bit ps, input logic [2:0] btn);
    @(negedge clk);
    reset   = rst;
    tick    = tk;
    pause   = ps;
    buttons = btn;
    for (int d = 0; d < 2; d++) model_step(d, rst, tk, ps, btn);
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
  endtask

  task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s dut%0d: got %h expected %h", nm, d, got, exp);
  endtask

  // Monitor: outputs are valid every cycle, so each edge consumes one expectation per instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("times", 0, 32'(times_a), 32'(e.t));
        check("active", 0, 32'(active_a), 32'(e.a));
        check("state", 0, 32'(state_a), 32'(e.s));
        check("flag_idx", 0, 32'(flag_a), 32'(e.f));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("times", 1, 32'(times_b), 32'(e.t));
        check("active", 1, 32'(active_b), 32'(e.a));
        check("state", 1, 32'(state_b), 32'(e.s));
        check("flag_idx", 1, 32'(flag_b), 32'(e.f));
      end
    end
  end

  initial begin
    logic [2:0] btn;
    bit         rst, tk, ps;
    int         r;

    // Reset then start with two buttons pressed: lowest index (P1) takes the turn.
    drive(0, 0, 0, 3'b000);
    drive(0, 1, 1, 3'b111);
    drive(1, 1, 1, 3'b000);
    drive(1, 0, 0, 3'b110);
    // Hand-off with increment, tick in the hand-off cycle.
    drive(1, 1, 0, 3'b000);
    drive(1, 1, 0, 3'b000);
    drive(1, 1, 0, 3'b010);
    // Run P2 down to 1, then flag with pause and button in the same cycle.
    repeat (4) drive(1, 1, 0, 3'b000);
    drive(1, 1, 1, 3'b100);
    for (int i = 0; i < 10; i++) drive(1, 1'(i % 2), 1'(i % 3 == 0), 3'(i));
    // Pause: everything frozen, then resume with the same player.
    drive(0, 0, 0, 3'b000);
    drive(1, 0, 0, 3'b001);
    drive(1, 0, 1, 3'b000);
    repeat (4) drive(1, 1, 0, 3'b111);
    drive(1, 0, 1, 3'b000);
    // Non-active buttons ignored; active hand-off with no tick (saturates on the narrow instance).
    drive(1, 0, 0, 3'b010);
    drive(1, 0, 0, 3'b100);
    drive(1, 0, 0, 3'b001);
    drive(1, 1, 0, 3'b000);
    // Mid-game reset.
    drive(0, 0, 0, 3'b000);
    drive(1, 0, 0, 3'b100);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) < ((m_st[0] == 3 || m_st[1] == 3) ? 15 : 1)) ? 1'b0 : 1'b1;
      tk  = 1'($urandom_range(0, 1));
      ps  = ($urandom_range(0, 11) == 0);
      r   = $urandom_range(0, 3);
      case (r)
        0:       btn = 3'b000;
        1:       btn = 3'($urandom_range(0, 7));
        2:       btn = 3'(1 << m_act[0]);
        default: btn = 3'(1 << m_act[1]);
      endcase
      drive(rst, tk, ps, btn);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q_a.size() == 0 && q_b.size() == 0) passed++;
    else $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
